dm_result_checker: RTL and testbench
====================================

// Module: dm_result_checker
// PURPOSE
//   Hardware end-of-test checker on the CPU data-memory port, downstream of the single-cycle core.
//   Snoops DM writes for the end-of-simulation code at SIM_END_ADDR, then scans the DM test region.
//   Compares that region word-by-word against a golden ROM and reports pass/fail, error count and cycle count.
//   Lets synthesized/FPGA builds self-check without a behavioural bench reading memory arrays.
// PARAMETERS
//   ADDR_W        14        DM word-address width
//   SIM_END_ADDR  'h3fff    word address whose full-word write of END_CODE ends the test
//   END_CODE      32'hFFFFFFFF  end-of-simulation code
//   TEST_START    'h2000    first DM word address of the result region
//   MAX_CYCLES    150000    run-phase cycle limit before timeout
//   CNT_W         32        cycle counter width
//   IDX_W         16        golden index / error counter width
// PORTS
//   clk            in   1       clock, all state on rising edge
//   rst            in   1       asynchronous, active-high reset
//   golden_num     in   IDX_W   number of golden words; sampled on entry to SCAN
//   dm_we          in   4       CPU DM byte write enables (snooped)
//   dm_addr        in   ADDR_W  CPU DM word address (snooped)
//   dm_wdata       in   32      CPU DM write data (snooped)
//   rd_en          out  1       checker read strobe to DM second read port
//   rd_addr        out  ADDR_W  checker DM read word address
//   rd_data        in   32      DM read data, valid 1 cycle after rd_en
//   gold_addr      out  IDX_W   golden ROM index, issued with rd_addr
//   gold_data      in   32      golden word, valid 1 cycle after gold_addr
//   done           out  1       test finished (end code seen or timeout), sticky
//   pass           out  1       done with zero errors and no timeout
//   timeout        out  1       MAX_CYCLES reached without end code, sticky
//   err_count      out  IDX_W   mismatching words, saturating
//   first_err_vld  out  1       at least one mismatch recorded
//   first_err_idx  out  IDX_W   index i of first mismatch
//   cycle_count    out  CNT_W   run-phase cycles, frozen after RUN exits
// BEHAVIOUR
//   - Reset (async): state=RUN; all outputs and counters 0; rd_en=0. Reset mid-SCAN aborts scan.
//   - States: RUN -> SCAN -> DONE; RUN -> TIMEOUT. DONE/TIMEOUT hold until reset.
//   - RUN: cycle_count += 1 every rising edge, including the end-detect edge.
//   - End detect (RUN only): dm_we==4'b1111 && dm_addr==SIM_END_ADDR && dm_wdata==END_CODE -> SCAN next edge.
//     Partial byte-enable writes, other addresses or other data do not trigger.
//   - Timeout: in RUN, when cycle_count would become MAX_CYCLES -> TIMEOUT. End detect on same edge wins (-> SCAN).
//   - SCAN pipeline: latch N=golden_num on entry; i=0. Each cycle while i<N:
//     rd_en=1, rd_addr=(TEST_START+i) mod 2^ADDR_W (wraps), gold_addr=i; i+=1.
//   - Compare stage one cycle later: mismatch if rd_data !== gold_data (any X/Z counts as mismatch).
//     On mismatch: err_count+=1, saturating at all-ones; first mismatch sets first_err_vld=1, first_err_idx=i.
//   - SCAN lasts N+1 cycles: N issues, then one drain cycle for the last compare -> DONE. rd_en=0 in drain.
//   - N=0: one SCAN cycle, no reads issued -> DONE with pass=1.
//   - DONE: done=1; pass=(err_count==0); rd_en=0; DM writes ignored.
//   - TIMEOUT: done=1, timeout=1, pass=0; no scan performed; err_count stays 0.
//   - Snooped writes in SCAN/DONE/TIMEOUT are ignored; a second end-code write does not restart.
// TESTING
//   1. End write at cycle 100, N=4, DM[0x2000..3] == golden -> done=1, pass=1, err_count=0, cycle_count=100.
//   2. N=4, DM[0x2002]=0xDEADBEEF, golden[2]=0x1 -> err_count=1, first_err_idx=2, pass=0.
//   3. dm_we=4'b0001 to 0x3fff with 0xFFFFFFFF -> no trigger; full-word write next cycle triggers SCAN.
//   4. No end write -> timeout=1, done=1, pass=0 at cycle_count=150000; end write at cycle 150000 -> SCAN instead.
//   5. N=0 -> DONE one cycle after SCAN entry, pass=1, rd_en never asserted.
//   6. Reset during SCAN (i=2 of 8) -> all outputs 0, RUN, cycle_count restarts at 0; a fresh run passes.

Source files
------------

// File: rtl/dm_result_checker.sv
`default_nettype none
// ============================================================================
//  Module      : dm_result_checker
//  Description : End-of-test checker on the CPU data-memory port. Watches DM
//                writes for a full-word END_CODE store to SIM_END_ADDR. It
//                then reads the DM result region through a second read port
//                and compares each word with a golden ROM. It reports
//                pass/fail, the error count, the first failing index and the
//                number of run-phase cycles. A run with no end code before
//                MAX_CYCLES is flagged as a timeout.
//  Ports       : clk, rst (async, active-high)
//                golden_num                 - golden word count, latched on SCAN entry
//                dm_we/dm_addr/dm_wdata     - snooped CPU DM write port
//                rd_en/rd_addr/rd_data      - DM read port (1-cycle latency)
//                gold_addr/gold_data        - golden ROM port (1-cycle latency)
//                done/pass/timeout          - final status, sticky until reset
//                err_count/first_err_vld/first_err_idx - mismatch reporting
//                cycle_count                - run-phase cycles, frozen after RUN
//  Revision    : 1.0 - initial release
// ============================================================================
module dm_result_checker #(
    parameter int                   ADDR_W       = 14,
    parameter logic [ADDR_W-1:0]    SIM_END_ADDR = 'h3fff,
    parameter logic [31:0]          END_CODE     = 32'hFFFF_FFFF,
    parameter logic [ADDR_W-1:0]    TEST_START   = 'h2000,
    parameter int                   MAX_CYCLES   = 150000,
    parameter int                   CNT_W        = 32,
    parameter int                   IDX_W        = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [IDX_W-1:0]    golden_num,
    input  logic [3:0]          dm_we,
    input  logic [ADDR_W-1:0]   dm_addr,
    input  logic [31:0]         dm_wdata,
    output logic                rd_en,
    output logic [ADDR_W-1:0]   rd_addr,
    input  logic [31:0]         rd_data,
    output logic [IDX_W-1:0]    gold_addr,
    input  logic [31:0]         gold_data,
    output logic                done,
    output logic                pass,
    output logic                timeout,
    output logic [IDX_W-1:0]    err_count,
    output logic                first_err_vld,
    output logic [IDX_W-1:0]    first_err_idx,
    output logic [CNT_W-1:0]    cycle_count
);

    localparam logic [CNT_W-1:0] c_max_cycles = CNT_W'(MAX_CYCLES);

    typedef enum logic [1:0] {
        S_RUN     = 2'd0,
        S_SCAN    = 2'd1,
        S_DONE    = 2'd2,
        S_TIMEOUT = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;

    logic [CNT_W-1:0]   r_cycle;
    logic [IDX_W-1:0]   r_num;          // golden word count latched on SCAN entry
    logic [IDX_W-1:0]   r_idx;          // next index to issue
    logic [IDX_W-1:0]   r_err_cnt;
    logic [IDX_W-1:0]   r_first_idx;
    logic               r_first_vld;
    logic               r_cmp_vld;      // a read was issued last cycle; its data is on rd_data now
    logic [IDX_W-1:0]   r_cmp_idx;      // index belonging to that read

    logic [CNT_W-1:0]   w_cycle_inc;
    logic               w_end_hit;
    logic               w_timeout_hit;
    logic               w_mismatch;

    assign w_cycle_inc   = r_cycle + CNT_W'(1);
    assign w_end_hit     = (dm_we == 4'b1111) && (dm_addr == SIM_END_ADDR) &&
                           (dm_wdata == END_CODE);
    assign w_timeout_hit = (w_cycle_inc == c_max_cycles);
    // Case-inequality so that undriven or unknown memory contents fail the check.
    assign w_mismatch    = (rd_data !== gold_data);

    // ------------------------------------------------------------------
    // Next state and outputs
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        rd_en       = 1'b0;
        rd_addr     = '0;
        gold_addr   = '0;
        done        = 1'b0;
        pass        = 1'b0;
        timeout     = 1'b0;

        case (r_state)
            S_RUN: begin
                // An end-code write on the same edge as the limit still wins.
                if (w_end_hit) begin
                    w_state_nxt = S_SCAN;
                end else if (w_timeout_hit) begin
                    w_state_nxt = S_TIMEOUT;
                end
            end
            S_SCAN: begin
                if (r_idx < r_num) begin
                    rd_en     = 1'b1;
                    // ADDR_W-wide sum: the region wraps at the top of DM.
                    rd_addr   = TEST_START + ADDR_W'(r_idx);
                    gold_addr = r_idx;
                end else begin
                    // Drain cycle: the last compare happens on this edge.
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                done = 1'b1;
                pass = (r_err_cnt == '0);
            end
            S_TIMEOUT: begin
                done    = 1'b1;
                timeout = 1'b1;
            end
            default: w_state_nxt = S_RUN;
        endcase
    end

    // ------------------------------------------------------------------
    // State, counters and compare stage
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_RUN;
            r_cycle     <= '0;
            r_num       <= '0;
            r_idx       <= '0;
            r_err_cnt   <= '0;
            r_first_idx <= '0;
            r_first_vld <= 1'b0;
            r_cmp_vld   <= 1'b0;
            r_cmp_idx   <= '0;
        end else begin
            r_state <= w_state_nxt;

            if (r_state == S_RUN) begin
                r_cycle <= w_cycle_inc;
                if (w_end_hit) begin
                    r_num <= golden_num;
                    r_idx <= '0;
                end
            end

            if (rd_en) begin
                r_idx <= r_idx + IDX_W'(1);
            end

            r_cmp_vld <= rd_en;
            r_cmp_idx <= r_idx;

            if (r_cmp_vld && w_mismatch) begin
                if (r_err_cnt != '1) begin
                    r_err_cnt <= r_err_cnt + IDX_W'(1);
                end
                if (!r_first_vld) begin
                    r_first_vld <= 1'b1;
                    r_first_idx <= r_cmp_idx;
                end
            end
        end
    end

    assign err_count     = r_err_cnt;
    assign first_err_vld = r_first_vld;
    assign first_err_idx = r_first_idx;
    assign cycle_count   = r_cycle;

endmodule
`default_nettype wire

// File: tb/tb_dm_result_checker.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dm_result_checker
//  Description : Directed self-checking bench for dm_result_checker. It holds
//                a small DM result region and a golden ROM, both with
//                1-cycle read latency. MAX_CYCLES is reduced to 300 so that
//                the timeout scenario stays short.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_dm_result_checker;

    localparam int TB_MAX = 300;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] golden_num = '0;
    logic [3:0]  dm_we = '0;
    logic [13:0] dm_addr = '0;
    logic [31:0] dm_wdata = '0;
    logic        rd_en;
    logic [13:0] rd_addr;
    logic [31:0] rd_data;
    logic [15:0] gold_addr;
    logic [31:0] gold_data;
    logic        done, pass, timeout, first_err_vld;
    logic [15:0] err_count, first_err_idx;
    logic [31:0] cycle_count;

    logic [31:0] dm_mem   [0:15];
    logic [31:0] gold_mem [0:15];
    int          rd_cnt = 0;
    int          checks = 0;
    int          errors = 0;
    int          rd_base;

    dm_result_checker #(
        .MAX_CYCLES (TB_MAX)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .golden_num    (golden_num),
        .dm_we         (dm_we),
        .dm_addr       (dm_addr),
        .dm_wdata      (dm_wdata),
        .rd_en         (rd_en),
        .rd_addr       (rd_addr),
        .rd_data       (rd_data),
        .gold_addr     (gold_addr),
        .gold_data     (gold_data),
        .done          (done),
        .pass          (pass),
        .timeout       (timeout),
        .err_count     (err_count),
        .first_err_vld (first_err_vld),
        .first_err_idx (first_err_idx),
        .cycle_count   (cycle_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        rd_data   <= dm_mem[rd_addr[3:0]];
        gold_data <= gold_mem[gold_addr[3:0]];
        if (rd_en) rd_cnt <= rd_cnt + 1;
    end

    task automatic load_match();
        for (int i = 0; i < 16; i++) begin
            dm_mem[i]   = 32'hA5A5_0000 + i * 32'h0101;
            gold_mem[i] = 32'hA5A5_0000 + i * 32'h0101;
        end
    endtask

    // Pulse reset across a negedge; cycle_count is 0 at the following negedge.
    task automatic apply_reset();
        rst = 1'b1;
        dm_we = '0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic idle_edges(input int n);
        dm_we = '0;
        repeat (n) @(negedge clk);
    endtask

    task automatic write_edge(input logic [3:0] we, input logic [13:0] a, input logic [31:0] d);
        dm_we = we; dm_addr = a; dm_wdata = d;
        @(negedge clk);
        dm_we = '0; dm_addr = '0; dm_wdata = '0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++;
        if ({done, pass, timeout, rd_en, first_err_vld} !== 5'b0) begin
            errors++;
            $display("FAIL reset_flags: got %b exp 00000", {done, pass, timeout, rd_en, first_err_vld});
        end
        checks++;
        if ({err_count, first_err_idx, cycle_count} !== 64'd0) begin
            errors++;
            $display("FAIL reset_counts: got %h exp 0", {err_count, first_err_idx, cycle_count});
        end
        rst = 1'b0;
    endtask

    task automatic test_pass();
        load_match();
        golden_num = 16'd4;
        apply_reset();
        idle_edges(99);
        write_edge(4'hF, 14'h3fff, 32'hFFFF_FFFF);
        rd_base = rd_cnt;
        checks++;
        if ({rd_en, rd_addr, gold_addr, done} !== {1'b1, 14'h2000, 16'd0, 1'b0}) begin
            errors++;
            $display("FAIL pass_first_issue: got en=%b a=%h g=%h d=%b exp 1 2000 0 0", rd_en, rd_addr, gold_addr, done);
        end
        idle_edges(4);
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL pass_early_done: got %b exp 0", done);
        end
        idle_edges(1);
        checks++;
        if ({done, pass, timeout, err_count} !== {3'b110, 16'd0}) begin
            errors++;
            $display("FAIL pass_status: got d=%b p=%b t=%b e=%0d exp 1 1 0 0", done, pass, timeout, err_count);
        end
        checks++;
        if (cycle_count !== 32'd100) begin
            errors++;
            $display("FAIL pass_cycles: got %0d exp 100", cycle_count);
        end
        checks++;
        if (rd_cnt - rd_base !== 4) begin
            errors++;
            $display("FAIL pass_reads: got %0d exp 4", rd_cnt - rd_base);
        end
        // A second end code after DONE must change nothing.
        write_edge(4'hF, 14'h3fff, 32'hFFFF_FFFF);
        idle_edges(1);
        checks++;
        if ({done, pass, rd_en, cycle_count} !== {3'b110, 32'd100}) begin
            errors++;
            $display("FAIL pass_second_end: got d=%b p=%b en=%b c=%0d exp 1 1 0 100", done, pass, rd_en, cycle_count);
        end
    endtask

    task automatic test_mismatch();
        load_match();
        dm_mem[2]   = 32'hDEAD_BEEF;
        gold_mem[2] = 32'h0000_0001;
        golden_num  = 16'd4;
        apply_reset();
        idle_edges(9);
        write_edge(4'hF, 14'h3fff, 32'hFFFF_FFFF);
        idle_edges(5);
        checks++;
        if ({done, pass, err_count} !== {2'b10, 16'd1}) begin
            errors++;
            $display("FAIL mismatch_status: got d=%b p=%b e=%0d exp 1 0 1", done, pass, err_count);
        end
        checks++;
        if ({first_err_vld, first_err_idx} !== {1'b1, 16'd2}) begin
            errors++;
            $display("FAIL mismatch_first: got v=%b i=%0d exp 1 2", first_err_vld, first_err_idx);
        end
    endtask

    task automatic test_multi_err();
        load_match();
        dm_mem[1] = 32'h0;
        dm_mem[3] = 32'h1234_5678;
        golden_num = 16'd6;
        apply_reset();
        idle_edges(9);
        write_edge(4'hF, 14'h3fff, 32'hFFFF_FFFF);
        idle_edges(7);
        checks++;
        if ({done, pass, err_count, first_err_idx} !== {2'b10, 16'd2, 16'd1}) begin
            errors++;
            $display("FAIL multi_err: got d=%b p=%b e=%0d i=%0d exp 1 0 2 1", done, pass, err_count, first_err_idx);
        end
    endtask

    task automatic test_partial();
        load_match();
        golden_num = 16'd2;
        apply_reset();
        idle_edges(19);
        write_edge(4'b0001, 14'h3fff, 32'hFFFF_FFFF);
        checks++;
        if ({rd_en, cycle_count} !== {1'b0, 32'd20}) begin
            errors++;
            $display("FAIL partial_no_trigger: got en=%b c=%0d exp 0 20", rd_en, cycle_count);
        end
        write_edge(4'hF, 14'h3ffe, 32'hFFFF_FFFF);
        write_edge(4'hF, 14'h3fff, 32'hFFFF_FFFE);
        checks++;
        if ({rd_en, cycle_count} !== {1'b0, 32'd22}) begin
            errors++;
            $display("FAIL wrong_addr_data: got en=%b c=%0d exp 0 22", rd_en, cycle_count);
        end
        write_edge(4'hF, 14'h3fff, 32'hFFFF_FFFF);
        checks++;
        if ({rd_en, cycle_count} !== {1'b1, 32'd23}) begin
            errors++;
            $display("FAIL full_trigger: got en=%b c=%0d exp 1 23", rd_en, cycle_count);
        end
        idle_edges(3);
        checks++;
        if ({done, pass, cycle_count} !== {2'b11, 32'd23}) begin
            errors++;
            $display("FAIL partial_done: got d=%b p=%b c=%0d exp 1 1 23", done, pass, cycle_count);
        end
    endtask

    task automatic test_timeout();
        load_match();
        golden_num = 16'd4;
        apply_reset();
        idle_edges(TB_MAX - 1);
        checks++;
        if ({done, timeout} !== 2'b00) begin
            errors++;
            $display("FAIL timeout_early: got d=%b t=%b exp 0 0", done, timeout);
        end
        idle_edges(1);
        checks++;
        if ({done, pass, timeout, rd_en, err_count, cycle_count} !== {4'b1010, 16'd0, 32'(TB_MAX)}) begin
            errors++;
            $display("FAIL timeout_status: got d=%b p=%b t=%b en=%b e=%0d c=%0d exp 1 0 1 0 0 %0d",
                     done, pass, timeout, rd_en, err_count, cycle_count, TB_MAX);
        end
        write_edge(4'hF, 14'h3fff, 32'hFFFF_FFFF);
        idle_edges(3);
        checks++;
        if ({done, timeout, rd_en, cycle_count} !== {3'b110, 32'(TB_MAX)}) begin
            errors++;
            $display("FAIL timeout_hold: got d=%b t=%b en=%b c=%0d exp 1 1 0 %0d", done, timeout, rd_en, cycle_count, TB_MAX);
        end
        // End code on the very edge the limit would be reached: scan wins.
        apply_reset();
        idle_edges(TB_MAX - 1);
        write_edge(4'hF, 14'h3fff, 32'hFFFF_FFFF);
        checks++;
        if ({timeout, rd_en, cycle_count} !== {2'b01, 32'(TB_MAX)}) begin
            errors++;
            $display("FAIL end_beats_timeout: got t=%b en=%b c=%0d exp 0 1 %0d", timeout, rd_en, cycle_count, TB_MAX);
        end
        idle_edges(5);
        checks++;
        if ({done, pass, timeout} !== 3'b110) begin
            errors++;
            $display("FAIL end_beats_timeout_done: got d=%b p=%b t=%b exp 1 1 0", done, pass, timeout);
        end
    endtask

    task automatic test_zero();
        load_match();
        golden_num = 16'd0;
        apply_reset();
        idle_edges(9);
        rd_base = rd_cnt;
        write_edge(4'hF, 14'h3fff, 32'hFFFF_FFFF);
        checks++;
        if ({done, rd_en} !== 2'b00) begin
            errors++;
            $display("FAIL zero_scan: got d=%b en=%b exp 0 0", done, rd_en);
        end
        idle_edges(1);
        checks++;
        if ({done, pass, err_count} !== {2'b11, 16'd0}) begin
            errors++;
            $display("FAIL zero_done: got d=%b p=%b e=%0d exp 1 1 0", done, pass, err_count);
        end
        checks++;
        if (rd_cnt != rd_base) begin
            errors++;
            $display("FAIL zero_reads: got %0d exp 0", rd_cnt - rd_base);
        end
    endtask

    task automatic test_reset_mid_scan();
        load_match();
        dm_mem[0] = 32'h0;   // would produce an error if the aborted scan leaked through
        golden_num = 16'd8;
        apply_reset();
        idle_edges(9);
        write_edge(4'hF, 14'h3fff, 32'hFFFF_FFFF);
        idle_edges(2);
        checks++;
        if ({rd_en, gold_addr, rd_addr} !== {1'b1, 16'd2, 14'h2002}) begin
            errors++;
            $display("FAIL mid_scan_idx: got en=%b g=%0d a=%h exp 1 2 2002", rd_en, gold_addr, rd_addr);
        end
        rst = 1'b1;
        #1;
        checks++;
        if ({done, pass, timeout, rd_en, first_err_vld, err_count, cycle_count} !== 53'd0) begin
            errors++;
            $display("FAIL mid_scan_reset: got d=%b p=%b t=%b en=%b v=%b e=%0d c=%0d exp all 0",
                     done, pass, timeout, rd_en, first_err_vld, err_count, cycle_count);
        end
        load_match();
        golden_num = 16'd4;
        @(negedge clk);
        rst = 1'b0;
        idle_edges(4);
        write_edge(4'hF, 14'h3fff, 32'hFFFF_FFFF);
        idle_edges(5);
        checks++;
        if ({done, pass, err_count, cycle_count} !== {2'b11, 16'd0, 32'd5}) begin
            errors++;
            $display("FAIL fresh_run: got d=%b p=%b e=%0d c=%0d exp 1 1 0 5", done, pass, err_count, cycle_count);
        end
    endtask

    initial begin
        load_match();
        test_reset();
        test_pass();
        test_mismatch();
        test_multi_err();
        test_partial();
        test_timeout();
        test_zero();
        test_reset_mid_scan();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
